instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2: instruction buffer entries; legal range 2..8.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_addr  output  32  word address of request; bits [1:0] always 2'b00 when imem_req_valid=1.
REQ-008 imem_rsp_valid  input  1  read data returned; in order, at least 1 cycle after acceptance.
REQ-009 imem_rsp_data  input  32  returned instruction word.
REQ-010 redirect_valid  input  1  branch/jump taken; flush and restart.
REQ-011 redirect_pc  input  32  new fetch address.
REQ-012 inst_valid  output  1  instruction presented to decoder.
REQ-013 inst_ready  input  1  decoder consumes instruction.
REQ-014 instruction  output  32  instruction word, fed to decoder instruction input.
REQ-015 inst_pc  output  32  address of presented instruction.
REQ-016 fetch_fault  output  1  misaligned redirect detected (present only with macro, see Configuration).

Function
REQ-017 States: IDLE, FETCH, DRAIN, HALT; encoding 2 bits.
REQ-018 IDLE: entered on reset; imem_req_valid=0; unconditionally go to FETCH next cycle.
REQ-019 FETCH: imem_req_valid=1 when (outstanding + buffer occupancy) < BUF_DEPTH; request accepted when imem_req_valid & imem_req_ready; fetch PC += 4 on acceptance.
REQ-020 Fetch PC wraps 32'hFFFF_FFFC -> 32'h0000_0000 without flag.
REQ-021 Responses written into FIFO buffer with their PC; inst_valid = buffer not empty; head popped when inst_valid & inst_ready.
REQ-022 Push and pop same cycle with full buffer: legal; occupancy unchanged; no loss.
REQ-023 Min latency: request accepted cycle N, response cycle N+1 -> inst_valid=1 cycle N+2.
REQ-024 instruction/inst_pc held stable while inst_valid=1 and inst_ready=0.
REQ-025 redirect_valid (any state except HALT) has priority over all else: buffer cleared, fetch PC <= redirect_pc, inst_valid=0 next cycle, no pop counted that cycle.
REQ-026 On redirect, drop count <= outstanding requests not completing that cycle; if nonzero go DRAIN, else FETCH.
REQ-027 DRAIN: imem_req_valid=0; each imem_rsp_valid decrements drop count and data is discarded; at zero go FETCH.
REQ-028 Redirect during DRAIN: fetch PC updated, drop count retained (outstanding unchanged).
REQ-029 imem_rsp_valid with zero outstanding: ignored.

Reset
REQ-030 While rst_n=0: state IDLE, fetch PC=RESET_PC, buffer empty, outstanding=0, drop count=0, imem_req_valid=0, inst_valid=0, imem_addr=RESET_PC, instruction=32'h0000_0013 (NOP), inst_pc=0, fetch_fault=0.
REQ-031 Reset assertion mid-transaction abandons all in-flight requests; responses after deassertion with zero outstanding ignored per REQ-029.

Configuration
REQ-032 Macro FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 sets fetch_fault=1, state HALT (no requests, inst_valid=0, redirects ignored) until reset.
REQ-033 Macro undefined: fetch_fault port absent; redirect_pc[1:0] forced to 00; HALT unreachable.

Structure
REQ-034 Shared package rv32i_pkg holds fetch state enum, XLEN=32, NOP_INSTR=32'h0000_0013, RESET_PC default.
REQ-035 One sub-module fetch_fifo (BUF_DEPTH x 64-bit {pc,instruction}, push/pop/full/empty/flush).

Verification
REQ-036 Reset, memory always ready, 1-cycle response, inst_ready=1 -> inst_pc sequence 0,4,8,12 on consecutive cycles from cycle 3.
REQ-037 inst_ready=0 for 10 cycles -> exactly BUF_DEPTH requests issued, instruction stable, then resume without loss or duplicate.
REQ-038 Redirect to 32'h0000_0100 with 2 requests outstanding -> two stale responses dropped, next inst_pc=32'h100.
REQ-039 Redirect to 32'hFFFF_FFFC -> inst_pc sequence FFFF_FFFC, 0000_0000.
REQ-040 With FETCH_MISALIGN_CHECK_EN, redirect to 32'h0000_0102 -> fetch_fault=1, imem_req_valid=0 until rst_n low; without macro -> fetch from 32'h100.
REQ-041 rst_n pulsed low mid-stream with response pending -> all outputs at reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared fetch types, word size and reset constants for the RV32I front end.
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} fetch_state_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of {pc, instruction} pairs with flush; push is accepted when full if a pop frees a slot.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        empty   = count == '0;
        full    = count == CW'(DEPTH);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: in-order instruction fetch with a BUF_DEPTH entry buffer, redirect flush and stale-response drain.
// Defining FETCH_MISALIGN_CHECK_EN adds fetch_fault and halts on a misaligned redirect until reset.
module instruction_fetch
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] inst_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            fetch_fault
`endif
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc, rsp_pc, target;
    logic [CW-1:0]   outstanding, drop_cnt, occupancy, out_next;
    logic [2*XLEN-1:0] head;
    logic            buf_empty, buf_full, take, req_fire, rsp_fire, redirect_go, push, pop;

    // A slot freed by this cycle's pop may be reused, so back-to-back fetch sustains one instruction per cycle.
    always_comb begin
        redirect_go    = redirect_valid && state != HALT;
        target         = align_pc(redirect_pc);
        take           = inst_valid && inst_ready;
        imem_req_valid = state == FETCH && (int'(outstanding) + int'(occupancy) - int'(take)) < BUF_DEPTH;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_fire       = imem_rsp_valid && outstanding != '0;
        out_next       = outstanding + CW'(req_fire) - CW'(rsp_fire);
        pop            = take && !redirect_go;
        push           = rsp_fire && state == FETCH && !redirect_go && (!buf_full || pop);
    end

    assign imem_addr   = fetch_pc;
    assign inst_valid  = !buf_empty;
    assign instruction = inst_valid ? head[XLEN-1:0] : NOP_INSTR;
    assign inst_pc     = inst_valid ? head[2*XLEN-1:XLEN] : '0;

    fetch_fifo #(
        .DEPTH(BUF_DEPTH),
        .W    (2 * XLEN)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .flush(redirect_go),
        .wdata({rsp_pc, imem_rsp_data}),
        .rdata(head),
        .full (buf_full),
        .empty(buf_empty),
        .count(occupancy)
    );

    // rsp_pc tracks the address of the next in-order response, so the buffer never stores request addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= align_pc(RESET_PC);
            rsp_pc      <= align_pc(RESET_PC);
            outstanding <= '0;
            drop_cnt    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fetch_fault <= 1'b0;
`endif
        end else begin
            outstanding <= out_next;
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            if (push) rsp_pc <= rsp_pc + XLEN'(4);
`ifdef FETCH_MISALIGN_CHECK_EN
            if (redirect_go && redirect_pc[1:0] != 2'b00) begin
                state       <= HALT;
                fetch_fault <= 1'b1;
            end else
`endif
            if (redirect_go) begin
                fetch_pc <= target;
                rsp_pc   <= target;
                drop_cnt <= out_next;
                state    <= out_next != '0 ? DRAIN : FETCH;
            end else begin
                case (state)
                    IDLE: state <= FETCH;
                    DRAIN: begin
                        drop_cnt <= drop_cnt - CW'(rsp_fire);
                        if (drop_cnt == CW'(rsp_fire)) state <= FETCH;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized scoreboard bench; expected stream is the sequential word sequence from the last redirect/reset.
module tb_instruction_fetch;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid, inst_ready = 1'b1;
    logic [31:0] instruction, inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    instruction_fetch #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .instruction   (instruction),
        .inst_pc       (inst_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_fault   (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    int          tests = 0, fails = 0;
    int          deliv = 0, cyc = 0, req_cnt = 0;
    int          rdy_pct = 100, rsp_pct = 100;
    bit          rsp_hold = 0, stale = 0;
    int          dcyc[$];
    logic [31:0] exp_q[$];
    logic [31:0] pend[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic start_stream(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 128; i++) exp_q.push_back(pc + 32'(4 * i));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        start_stream(pc & 32'hFFFF_FFFC);
        tick(1);
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        tick(1);
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_inst_valid", 32'(inst_valid), 0);
        chk("rst_imem_addr", imem_addr, RPC);
        chk("rst_instruction", instruction, NOP);
        chk("rst_inst_pc", inst_pc, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst_fetch_fault", 32'(fetch_fault), 0);
`endif
        rsp_hold = 0;
        tick(2);
        start_stream(RPC);
        rst_n = 1'b1;
    endtask

    task automatic wait_deliv(input int n, input int budget);
        int tgt = deliv + n;
        int k = 0;
        while (deliv < tgt && k < budget) begin
            tick(1);
            k++;
        end
        chk("deliver_in_time", 32'(deliv >= tgt), 1);
    endtask

    // Memory model: in-order responses, at least one cycle after acceptance.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend.delete();
                req_cnt = 0;
                stale   = 1;
            end else if (imem_req_valid && imem_req_ready) begin
                chk("addr_aligned", 32'(imem_addr[1:0]), 0);
                pend.push_back(imem_addr);
                req_cnt++;
            end
            @(posedge clk);
            #2;
            imem_req_ready = $urandom_range(99) < rdy_pct;
            imem_rsp_data  = $urandom;
            imem_rsp_valid = 1'b0;
            if (!rst_n) imem_rsp_valid = 1'($urandom_range(1));
            else if (stale) begin
                imem_rsp_valid = 1'b1;
                stale          = 0;
            end else if (pend.size() > 0 && !rsp_hold && $urandom_range(99) < rsp_pct) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend.pop_front());
            end
        end
    end

    // Monitor: pops the scoreboard on every consumed instruction.
    initial begin
        logic [31:0] prev_pc, prev_in, e;
        logic        prev_stall, prev_redir;
        prev_stall = 0;
        prev_redir = 0;
        prev_pc    = '0;
        prev_in    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc        = 0;
                prev_stall = 0;
                dcyc.delete();
            end else begin
                if (inst_valid && prev_stall && !prev_redir) begin
                    chk("stable_pc", inst_pc, prev_pc);
                    chk("stable_instr", instruction, prev_in);
                end
                if (inst_valid && inst_ready && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_inst: got pc %h expected none", inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("inst_pc", inst_pc, e);
                        chk("instruction", instruction, mem_word(e));
                    end
                    deliv++;
                    dcyc.push_back(cyc);
                end
                prev_stall = inst_valid && !inst_ready;
                prev_pc    = inst_pc;
                prev_in    = instruction;
                prev_redir = redirect_valid;
                cyc++;
            end
        end
    end

    initial begin
        int          k, start;
        logic [31:0] pc;
        inst_ready = 1'b1;
        do_reset();
        wait_deliv(4, 40);
        if (dcyc.size() >= 4)
            for (int i = 0; i < 4; i++) chk("deliver_cycle", 32'(dcyc[i]), 32'(3 + i));
        else chk("deliver_count", 32'(dcyc.size()), 4);

        inst_ready = 1'b0;
        do_reset();
        tick(12);
        chk("stall_requests", 32'(req_cnt), DEPTH);
        chk("stall_valid", 32'(inst_valid), 1);
        chk("stall_pc", inst_pc, RPC);
        inst_ready = 1'b1;
        wait_deliv(8, 60);

        rsp_hold = 1;
        k = 0;
        while (pend.size() < 2 && k < 30) begin
            tick(1);
            k++;
        end
        chk("two_outstanding", 32'(pend.size()), 2);
        redirect(32'h0000_0100);
        rsp_hold = 0;
        wait_deliv(3, 60);

        redirect(32'hFFFF_FFFC);
        wait_deliv(3, 60);

`ifdef FETCH_MISALIGN_CHECK_EN
        redirect(32'h0000_0102);
        exp_q.delete();
        tick(1);
        for (int i = 0; i < 5; i++) begin
            chk("halt_fault", 32'(fetch_fault), 1);
            chk("halt_no_req", 32'(imem_req_valid), 0);
            chk("halt_no_inst", 32'(inst_valid), 0);
            tick(1);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick(1);
        redirect_valid = 1'b0;
        tick(3);
        chk("halt_ignores_redirect", 32'(imem_req_valid), 0);
        do_reset();
        wait_deliv(3, 60);
`else
        redirect(32'h0000_0102);
        wait_deliv(3, 60);
`endif

        rsp_hold = 1;
        k = 0;
        while (pend.size() < 1 && k < 30) begin
            tick(1);
            k++;
        end
        chk("pending_before_reset", 32'(pend.size() > 0), 1);
        do_reset();
        wait_deliv(4, 60);

        rdy_pct = 70;
        rsp_pct = 60;
        start   = deliv;
        for (int i = 0; i < 600; i++) begin
            inst_ready = $urandom_range(99) < 75;
            if ($urandom_range(99) < 4 || exp_q.size() < 16) begin
                pc = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
                pc[1:0] = 2'b00;
`endif
                redirect(pc);
            end else tick(1);
        end
        inst_ready = 1'b1;
        rdy_pct    = 100;
        rsp_pct    = 100;
        wait_deliv(5, 100);
        chk("random_progress", 32'(deliv - start > 50), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
